// File: rtl/line_burst_adaptor.sv
// Adapts whole-line cache requests to a four-beat memory burst interface and back.
// Optional perf counters are built in when LINE_BURST_ADAPTOR_PERF_EN is defined.
module line_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef LINE_BURST_ADAPTOR_PERF_EN
  ,
  output logic [31:0]        perf_rd_lines,
  output logic [31:0]        perf_wr_lines
`endif
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [31:0]        addr_reg, addr_next;
  logic [LINE_W-1:0]  wbuf_reg, wbuf_next;
  logic               is_wr_reg, is_wr_next;
  logic               beat_store;
  logic [BURST_W-1:0] wbeat [BEATS];
  logic               addr_off_unused;

  // Byte offset within the line is dropped; the memory side is line-addressed.
  assign addr_off_unused = ^address_i[OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wbuf_reg  <= '0;
      is_wr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wbuf_reg  <= wbuf_next;
      is_wr_reg <= is_wr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wbuf_next  = wbuf_reg;
    is_wr_next = is_wr_reg;
    beat_store = 1'b0;
    case (state_reg)
      IDLE: begin
        // Write has priority; a concurrent read simply stays asserted upstream.
        if (write_i || read_i) begin
          addr_next  = {address_i[31:OFF_W], {OFF_W{1'b0}}};
          wbuf_next  = line_i;
          cnt_next   = '0;
          is_wr_next = write_i;
          state_next = write_i ? WRITE : READ;
        end
      end
      READ: begin
        if (resp_i) begin
          beat_store = 1'b1;
          cnt_next   = (cnt_reg == LAST_BEAT) ? '0 : cnt_reg + 1'b1;
          if (cnt_reg == LAST_BEAT) state_next = DONE;
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_next = (cnt_reg == LAST_BEAT) ? '0 : cnt_reg + 1'b1;
          if (cnt_reg == LAST_BEAT) state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      logic [BURST_W-1:0] slot_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (beat_store && cnt_reg == CNT_W'(gi)) begin
          slot_reg <= burst_i;
        end
      end

      assign line_o[gi*BURST_W +: BURST_W] = slot_reg;
      assign wbeat[gi] = wbuf_reg[gi*BURST_W +: BURST_W];
    end
  endgenerate

  assign address_o = addr_reg;
  assign read_o    = (state_reg == READ);
  assign write_o   = (state_reg == WRITE);
  assign resp_o    = (state_reg == DONE);
  assign burst_o   = (state_reg == WRITE) ? wbeat[cnt_reg] : '0;

`ifdef LINE_BURST_ADAPTOR_PERF_EN
  logic [31:0] perf_rd_reg, perf_wr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_reg <= '0;
      perf_wr_reg <= '0;
    end else if (state_reg == DONE) begin
      if (is_wr_reg && perf_wr_reg != 32'hFFFF_FFFF) perf_wr_reg <= perf_wr_reg + 32'd1;
      if (!is_wr_reg && perf_rd_reg != 32'hFFFF_FFFF) perf_rd_reg <= perf_rd_reg + 32'd1;
    end
  end

  assign perf_rd_lines = perf_rd_reg;
  assign perf_wr_lines = perf_wr_reg;
`endif

endmodule
